// File: rtl/opc_enc_pkg.sv
// rtl/opc_enc_pkg.sv - format codes, word kinds, FSM states, base opcodes and the VM1 unimplemented-opcode test.
package opc_enc_pkg;

  localparam logic [2:0] FMT_DOUBLE  = 3'd0;
  localparam logic [2:0] FMT_SINGLE  = 3'd1;
  localparam logic [2:0] FMT_BRANCH  = 3'd2;
  localparam logic [2:0] FMT_RSD     = 3'd3;
  localparam logic [2:0] FMT_SOB     = 3'd4;
  localparam logic [2:0] FMT_IMPLIED = 3'd5;

  localparam logic [1:0] KIND_OPC  = 2'd0;
  localparam logic [1:0] KIND_SRCX = 2'd1;
  localparam logic [1:0] KIND_DSTX = 2'd2;

  localparam logic [15:0] OP_MOV  = 16'o010000;
  localparam logic [15:0] OP_CMP  = 16'o020000;
  localparam logic [15:0] OP_ADD  = 16'o060000;
  localparam logic [15:0] OP_SUB  = 16'o160000;
  localparam logic [15:0] OP_CLR  = 16'o005000;
  localparam logic [15:0] OP_INC  = 16'o005200;
  localparam logic [15:0] OP_BR   = 16'o000400;
  localparam logic [15:0] OP_BNE  = 16'o001000;
  localparam logic [15:0] OP_JSR  = 16'o004000;
  localparam logic [15:0] OP_XOR  = 16'o074000;
  localparam logic [15:0] OP_SOB  = 16'o077000;
  localparam logic [15:0] OP_NOP  = 16'o000240;
  localparam logic [15:0] OP_HALT = 16'o000000;
  localparam logic [15:0] OP_MFPI = 16'o006500;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPC,
    ST_SRCX,
    ST_DSTX
  } enc_state_e;

  // Opcodes the 1801VM1 traps on even though other PDP-11 models implement them.
  function automatic logic vm1_unimpl(input logic [15:0] w);
    return (w[15:6] == 10'o0065) || (w[15:6] == 10'o0066) ||
           (w == 16'o000007) ||
           (w >= 16'o000010 && w <= 16'o000037) ||
           (w >= 16'o000210 && w <= 16'o000227) ||
           (w[15:9] == 7'o007) ||
           (w[15:9] == 7'o075 && (w[8:6] != 3'd0 || w[5])) ||
           (w[15:9] == 7'o076) ||
           (w[15:9] == 7'o107) ||
           (w == 16'o177777);
  endfunction

endpackage

// File: rtl/opc_ext_need.sv
// rtl/opc_ext_need.sv - flags an operand mode/reg that is followed by an extension word.
module opc_ext_need (
  input  logic [5:0] ea_i,
  output logic       need_o
);

  logic [2:0] mode;
  logic [2:0] rn;

  assign mode = ea_i[5:3];
  assign rn   = ea_i[2:0];
  // Index/index-deferred always, immediate/absolute via PC autoincrement.
  assign need_o = (mode == 3'd6) || (mode == 3'd7) ||
                  (((mode == 3'd2) || (mode == 3'd3)) && (rn == 3'd7));

endmodule

// File: rtl/opc_encoder.sv
// rtl/opc_encoder.sv - PDP-11/1801VM1 instruction encoder streaming opcode plus extension words.
// Optional: ENC_STRICT_VM1_EN rejects opcodes the VM1 does not implement.
module opc_encoder
  import opc_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_fmt,
  input  logic [15:0]      req_base,
  input  logic [5:0]       req_src,
  input  logic [5:0]       req_dst,
  input  logic [7:0]       req_off,
  input  logic [15:0]      req_sx,
  input  logic [15:0]      req_dx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_word,
  output logic [1:0]       out_kind,
  output logic             out_last,
  output logic             err,
  output logic [CNT_W-1:0] word_cnt
);

  enc_state_e state_q, state_d;
  logic [15:0] opc_q, sx_q, dx_q;
  logic        nsrc_q, ndst_q, err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [15:0] opc_c;
  logic        src_ext, dst_ext, need_src_c, need_dst_c;
  logic        accept, illegal, handshake;

  opc_ext_need u_src_need (.ea_i(req_src), .need_o(src_ext));
  opc_ext_need u_dst_need (.ea_i(req_dst), .need_o(dst_ext));

  always_comb begin
    opc_c = req_base;
    unique case (req_fmt)
      FMT_DOUBLE: opc_c = req_base | {4'b0, req_src, 6'b0} | {10'b0, req_dst};
      FMT_SINGLE: opc_c = req_base | {10'b0, req_dst};
      FMT_BRANCH: opc_c = req_base | {8'b0, req_off};
      FMT_RSD:    opc_c = req_base | {7'b0, req_src[2:0], 6'b0} | {10'b0, req_dst};
      FMT_SOB:    opc_c = req_base | {7'b0, req_src[2:0], 6'b0} | {10'b0, req_off[5:0]};
      default:    opc_c = req_base;
    endcase
  end

  assign need_src_c = (req_fmt == FMT_DOUBLE) && src_ext;
  assign need_dst_c = ((req_fmt == FMT_DOUBLE) || (req_fmt == FMT_SINGLE) ||
                       (req_fmt == FMT_RSD)) && dst_ext;

`ifdef ENC_STRICT_VM1_EN
  assign illegal = (req_fmt > FMT_IMPLIED) || vm1_unimpl(opc_c);
`else
  assign illegal = (req_fmt > FMT_IMPLIED);
`endif

  assign accept    = req_valid && req_ready;
  assign handshake = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    out_valid = 1'b0;
    out_word  = 16'd0;
    out_kind  = KIND_OPC;
    out_last  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !illegal) state_d = ST_OPC;
      end
      ST_OPC: begin
        out_valid = 1'b1;
        out_word  = opc_q;
        out_last  = !nsrc_q && !ndst_q;
        if (out_ready) state_d = nsrc_q ? ST_SRCX : (ndst_q ? ST_DSTX : ST_IDLE);
      end
      ST_SRCX: begin
        out_valid = 1'b1;
        out_word  = sx_q;
        out_kind  = KIND_SRCX;
        out_last  = !ndst_q;
        if (out_ready) state_d = ndst_q ? ST_DSTX : ST_IDLE;
      end
      ST_DSTX: begin
        out_valid = 1'b1;
        out_word  = dx_q;
        out_kind  = KIND_DSTX;
        out_last  = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      opc_q   <= 16'd0;
      sx_q    <= 16'd0;
      dx_q    <= 16'd0;
      nsrc_q  <= 1'b0;
      ndst_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && illegal;
      if (accept) begin
        opc_q  <= opc_c;
        sx_q   <= req_sx;
        dx_q   <= req_dx;
        nsrc_q <= need_src_c;
        ndst_q <= need_dst_c;
      end
      if (handshake) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign err      = err_q;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_opc_encoder.sv
// tb/tb_opc_encoder.sv - scoreboard bench for opc_encoder with directed and randomized requests.
module tb_opc_encoder;
  import opc_enc_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_fmt = '0;
  logic [15:0] req_base = '0;
  logic [5:0]  req_src = '0;
  logic [5:0]  req_dst = '0;
  logic [7:0]  req_off = '0;
  logic [15:0] req_sx = '0;
  logic [15:0] req_dx = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_word;
  logic [1:0]  out_kind;
  logic        out_last;
  logic        err;
  logic [15:0] word_cnt;

  opc_encoder #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt(req_fmt), .req_base(req_base), .req_src(req_src), .req_dst(req_dst),
    .req_off(req_off), .req_sx(req_sx), .req_dx(req_dx),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_kind(out_kind), .out_last(out_last), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] w;
    logic [1:0]  k;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   pending_err = 0;
  int   checks = 0;
  int   failures = 0;
  int   exp_total = 0;
  int   rdy_mode = 1;
  int   stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0o required=%0o", name, act, req);
    end
  endtask

  // 0 random, 1 always ready, 2 never ready, 3 three stall cycles per word, 4 driven by the sequence.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = ($urandom_range(3) != 0);
      1: out_ready = 1'b1;
      2: out_ready = 1'b0;
      3: begin
        out_ready = (stall_cnt == 3);
        stall_cnt = out_ready ? 0 : stall_cnt + 1;
      end
      default: ;
    endcase
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (err) begin
        checks++;
        if (pending_err == 0) begin
          failures++;
          $display("FAIL unexpected_err actual=1 required=0");
        end else pending_err--;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0o required=none", out_word);
        end else begin
          check("out_word", out_word, exp_q[0].w);
          check("out_kind", out_kind, exp_q[0].k);
          check("out_last", out_last, exp_q[0].l);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic bit ext_needed(input logic [5:0] ea);
    int mode = ea / 8;
    int rn   = ea % 8;
    return mode >= 6 || ((mode == 2 || mode == 3) && rn == 7);
  endfunction

  function automatic bit strict_reject(input logic [15:0] w);
`ifdef ENC_STRICT_VM1_EN
    return (w >= 16'o006500 && w <= 16'o006677) || w == 16'o000007 ||
           (w >= 16'o000010 && w <= 16'o000037) || (w >= 16'o000210 && w <= 16'o000227) ||
           (w >= 16'o007000 && w <= 16'o007777) || (w >= 16'o075040 && w <= 16'o076777) ||
           (w >= 16'o107000 && w <= 16'o107777) || w == 16'o177777;
`else
    return w == 16'o000000 && w != 16'o000000;
`endif
  endfunction

  task automatic expect_word(input logic [15:0] w, input logic [1:0] k, input logic l);
    exp_t e;
    e.w = w; e.k = k; e.l = l;
    exp_q.push_back(e);
    exp_total++;
  endtask

  task automatic model_push(input int f, input logic [15:0] b, input logic [5:0] s, input logic [5:0] d,
                            input logic [7:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] w;
    bit ns, nd;
    w = b; ns = 0; nd = 0;
    if (f == 0) begin w = b | (16'(s) * 64) | 16'(d); ns = ext_needed(s); nd = ext_needed(d); end
    if (f == 1) begin w = b | 16'(d); nd = ext_needed(d); end
    if (f == 2) w = b | 16'(o);
    if (f == 3) begin w = b | (16'(s % 8) * 64) | 16'(d); nd = ext_needed(d); end
    if (f == 4) w = b | (16'(s % 8) * 64) | 16'(o % 64);
    if (f > 5 || strict_reject(w)) pending_err++;
    else begin
      expect_word(w, 2'd0, !ns && !nd);
      if (ns) expect_word(x, 2'd1, !nd);
      if (nd) expect_word(y, 2'd2, 1'b1);
    end
  endtask

  task automatic issue(input int f, input logic [15:0] b, input logic [5:0] s, input logic [5:0] d,
                       input logic [7:0] o, input logic [15:0] x, input logic [15:0] y);
    int n = 0;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL req_ready_timeout actual=0 required=1");
    end
    req_fmt = 3'(f); req_base = b; req_src = s; req_dst = d;
    req_off = o; req_sx = x; req_dx = y; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_fmt = 3'($urandom); req_src = 6'($urandom); req_dst = 6'($urandom);
    req_sx = 16'($urandom); req_dx = 16'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(exp_q.size() == 0 && pending_err == 0 && req_ready && !out_valid) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("drain_done", n < 300, 1);
    check("word_cnt", word_cnt, 16'(exp_total));
  endtask

  logic [15:0] bases[8];

  initial begin
    bases[0] = OP_MOV; bases[1] = OP_ADD; bases[2] = OP_CLR; bases[3] = OP_BNE;
    bases[4] = OP_JSR; bases[5] = OP_SOB; bases[6] = OP_NOP; bases[7] = OP_MFPI;

    #2;
    check("rst_req_ready", req_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_kind", out_kind, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err", err, 0);
    check("rst_word_cnt", word_cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    rdy_mode = 1;
    expect_word(16'o012737, 2'd0, 1'b0);
    expect_word(16'o001234, 2'd1, 1'b0);
    expect_word(16'o177566, 2'd2, 1'b1);
    issue(0, OP_MOV, 6'o27, 6'o37, 8'd0, 16'o001234, 16'o177566);
    wait_done();
    check("mov_word_cnt3", word_cnt, 3);

    expect_word(16'o000776, 2'd0, 1'b1);
    issue(2, OP_BR, 6'd0, 6'd0, 8'o376, 16'd0, 16'd0);
    check("br_latency_valid", out_valid, 1);
    check("br_busy_ready", req_ready, 0);
    @(posedge clk); #1;
    check("br_ready_after_last", req_ready, 1);
    check("br_valid_after_last", out_valid, 0);
    wait_done();

    expect_word(16'o077105, 2'd0, 1'b1);
    issue(4, OP_SOB, 6'o01, 6'd0, 8'd5, 16'd0, 16'd0);
    wait_done();
    expect_word(16'o004737, 2'd0, 1'b0);
    expect_word(16'o001000, 2'd2, 1'b1);
    issue(3, OP_JSR, 6'o07, 6'o37, 8'd0, 16'd0, 16'o001000);
    wait_done();

    rdy_mode = 3; stall_cnt = 0;
    expect_word(16'o016701, 2'd0, 1'b0);
    expect_word(16'o004444, 2'd1, 1'b1);
    issue(0, OP_MOV, 6'o67, 6'o01, 8'd0, 16'o004444, 16'o111111);
    wait_done();

    rdy_mode = 1;
    pending_err++;
    issue(6, OP_MOV, 6'o27, 6'o37, 8'd0, 16'd1, 16'd2);
    check("err_pulse", err, 1);
    check("err_no_valid", out_valid, 0);
    @(posedge clk); #1;
    check("err_one_cycle", err, 0);
    check("err_idle_ready", req_ready, 1);
    wait_done();

`ifdef ENC_STRICT_VM1_EN
    pending_err++;
`else
    expect_word(16'o006500, 2'd0, 1'b1);
`endif
    issue(1, OP_MFPI, 6'd0, 6'd0, 8'd0, 16'd0, 16'd0);
    wait_done();

    rdy_mode = 0;
    for (int i = 0; i < 60; i++) begin
      int f;
      logic [15:0] b, x, y;
      logic [5:0] s, d;
      logic [7:0] o;
      f = $urandom_range(7);
      b = bases[$urandom_range(7)];
      s = 6'($urandom); d = 6'($urandom); o = 8'($urandom);
      x = 16'($urandom); y = 16'($urandom);
      model_push(f, b, s, d, o, x, y);
      issue(f, b, s, d, o, x, y);
      wait_done();
    end

    rdy_mode = 4; out_ready = 1'b0;
    expect_word(16'o012737, 2'd0, 1'b0);
    expect_word(16'o000111, 2'd1, 1'b0);
    expect_word(16'o000222, 2'd2, 1'b1);
    issue(0, OP_MOV, 6'o27, 6'o37, 8'd0, 16'o000111, 16'o000222);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("srcx_kind_before_reset", out_kind, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_word_cnt", word_cnt, 0);
    exp_q.delete();
    exp_total = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    rdy_mode = 1;
    expect_word(16'o000240, 2'd0, 1'b1);
    issue(5, OP_NOP, 6'd0, 6'd0, 8'd0, 16'd0, 16'd0);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
